// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//   Drain engine for an 8-bit single-clock FIFO. It pops one byte at a time
//   and sends it LSB-first as an async serial frame:
//   start, 8 data bits, optional parity bit, STOP_BITS stop bits.
//
//   Optional feature: define UART_TX_PARITY_EN to add an even-parity bit
//   between the data bits and the stop bit(s).
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   STOP_BITS     number of stop bits (1 or 2)
//
// Ports
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   enable      in   allow new frames to start (sampled in IDLE only)
//   fifo_q      in   FIFO read data, valid the cycle after fifo_rdreq
//   fifo_empty  in   FIFO empty flag
//   fifo_rdreq  out  FIFO read request, one-cycle pulse
//   tx          out  serial line, idle high
//   busy        out  high from the read pulse through the last stop cycle
//   byte_count  out  frames completed since reset (wraps)
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [7:0]  fifo_q,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    output logic        tx,
    output logic        busy,
    output logic [15:0] byte_count
);

    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          rdreq_q, rdreq_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          baud_last;
`ifdef UART_TX_PARITY_EN
    logic          parity_q, parity_d;
`endif

    assign baud_last = (baud_q == BW'(CLKS_PER_BIT - 1));

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rdreq_d = 1'b0;
        cnt_d   = cnt_q;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                bit_d  = '0;
                if (enable && !fifo_empty) begin
                    rdreq_d = 1'b1;
                    state_d = S_FETCH;
                end
            end
            // FIFO samples the request at the end of this cycle; data
            // shows up on fifo_q during LOAD.
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                shift_d = fifo_q;
                baud_d  = '0;
                bit_d   = '0;
`ifdef UART_TX_PARITY_EN
                parity_d = ^fifo_q;
`endif
                state_d = S_START;
            end
            S_START: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d  = '0;
                    state_d = S_STOP;
                end
            end
`endif
            // bit_q counts stop bits here.
            S_STOP: begin
                baud_d = baud_q + BW'(1);
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        bit_d   = '0;
                        cnt_d   = cnt_q + 16'd1;
                        state_d = S_IDLE;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // tx is the registered image of the current state, so the line trails
    // the state by one cycle: read pulse, FETCH, LOAD, then start bit.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = parity_q;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // Covers the cycle after STOP too, which is the registered last stop bit.
    assign busy_d = (state_d != S_IDLE) || (state_q != S_IDLE);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            rdreq_q  <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            cnt_q    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            rdreq_q  <= rdreq_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign fifo_rdreq = rdreq_q;
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign byte_count = cnt_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//   Directed/randomized bench for fifo_uart_tx with CLKS_PER_BIT=4,
//   STOP_BITS=1. A behavioural FIFO feeds the DUT; the expected serial line
//   is computed per cycle from the byte value and the offset from the read
//   pulse.
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int LAST_T = 3 + NBITS * CPB - 1;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [7:0]  fifo_q = 8'h00;
    logic        fifo_empty;
    logic        fifo_rdreq;
    logic        tx;
    logic        busy;
    logic [15:0] byte_count;

    int vectors    = 0;
    int miscompares = 0;
    int cnt_exp    = 0;

    fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .fifo_q     (fifo_q),
        .fifo_empty (fifo_empty),
        .fifo_rdreq (fifo_rdreq),
        .tx         (tx),
        .busy       (busy),
        .byte_count (byte_count)
    );

    always #5 clock = ~clock;

    // Behavioural FIFO: registered read, one byte per request.
    logic [7:0] mem [0:255];
    int wp = 0;
    int rp = 0;
    assign fifo_empty = (wp == rp);
    always @(posedge clock) begin
        if (fifo_rdreq && (rp != wp)) begin
            fifo_q <= mem[rp[7:0]];
            rp     <= rp + 1;
        end
    end

    task automatic push(input logic [7:0] b);
        mem[wp[7:0]] = b;
        wp = wp + 1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level t cycles after the read-pulse cycle.
    function automatic logic line_model(input logic [7:0] b, input int t);
        int j;
        if (t < 3) return 1'b1;
        j = (t - 3) / CPB;
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    task automatic wait_rdreq(output bit got);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (fifo_rdreq === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("rdreq_wait", {15'd0, got}, 16'd1);
    endtask

    // Entered at the negedge where fifo_rdreq is high (t=0).
    task automatic check_frame(input logic [7:0] b, input int drop_t, input int abort_t);
        chk("tx_t0", {15'd0, tx}, 16'd1);
        chk("busy_t0", {15'd0, busy}, 16'd1);
        for (int t = 1; t <= LAST_T; t++) begin
            @(negedge clock);
            if (t == abort_t) return;
            if (t == drop_t) enable = 1'b0;
            chk($sformatf("tx[%02h]t%0d", b, t), {15'd0, tx}, {15'd0, line_model(b, t)});
            chk("busy_frame", {15'd0, busy}, 16'd1);
            chk("rdreq_frame", {15'd0, fifo_rdreq}, 16'd0);
        end
    endtask

    initial begin
        bit got;
        logic [7:0] rb [0:5];
        logic [7:0] r1, r2, r3;

        reset_n = 1'b0;
        enable  = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_tx", {15'd0, tx}, 16'd1);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_rdreq", {15'd0, fifo_rdreq}, 16'd0);
        chk("rst_cnt", byte_count, 16'd0);
        reset_n = 1'b1;
        enable  = 1'b1;

        // Single byte 0x55
        push(8'h55);
        wait_rdreq(got);
        if (got) check_frame(8'h55, -1, -1);
        @(negedge clock);
        cnt_exp++;
        chk("t1_cnt", byte_count, 16'(cnt_exp));
        chk("t1_busy", {15'd0, busy}, 16'd0);
        chk("t1_rdreq", {15'd0, fifo_rdreq}, 16'd0);

        // Empty FIFO, enabled: nothing moves
        for (int i = 0; i < 500; i++) begin
            @(negedge clock);
            chk("empty_rdreq", {15'd0, fifo_rdreq}, 16'd0);
            chk("empty_busy", {15'd0, busy}, 16'd0);
            chk("empty_tx", {15'd0, tx}, 16'd1);
        end

        // Back-to-back 0xA1, 0x02, 0xFF then six random bytes
        push(8'hA1); push(8'h02); push(8'hFF);
        wait_rdreq(got);
        if (got) begin
            check_frame(8'hA1, -1, -1);
            @(negedge clock); chk("b2b_gap", {15'd0, fifo_rdreq}, 16'd1);
            check_frame(8'h02, -1, -1);
            @(negedge clock); chk("b2b_gap", {15'd0, fifo_rdreq}, 16'd1);
            check_frame(8'hFF, -1, -1);
        end
        @(negedge clock);
        cnt_exp += 3;
        chk("t3_cnt", byte_count, 16'(cnt_exp));
        chk("t3_busy", {15'd0, busy}, 16'd0);

        for (int i = 0; i < 6; i++) begin
            rb[i] = 8'($urandom);
            push(rb[i]);
        end
        wait_rdreq(got);
        if (got) begin
            for (int i = 0; i < 6; i++) begin
                check_frame(rb[i], -1, -1);
                @(negedge clock);
                if (i < 5) chk("rnd_gap", {15'd0, fifo_rdreq}, 16'd1);
            end
        end
        cnt_exp += 6;
        chk("rnd_cnt", byte_count, 16'(cnt_exp));

        // Enable drop during START: frame completes, then holds off
        r1 = 8'($urandom);
        r2 = 8'($urandom);
        push(8'h3C); push(r1); push(r2);
        wait_rdreq(got);
        if (got) check_frame(8'h3C, 4, -1);
        @(negedge clock);
        cnt_exp++;
        chk("t5_cnt", byte_count, 16'(cnt_exp));
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            chk("t5_hold_rdreq", {15'd0, fifo_rdreq}, 16'd0);
            chk("t5_hold_tx", {15'd0, tx}, 16'd1);
        end
        enable = 1'b1;
        wait_rdreq(got);
        if (got) begin
            check_frame(r1, -1, -1);
            @(negedge clock); chk("t5_gap", {15'd0, fifo_rdreq}, 16'd1);
            check_frame(r2, -1, -1);
        end
        @(negedge clock);
        cnt_exp += 2;
        chk("t5_cnt2", byte_count, 16'(cnt_exp));

        // Reset during DATA bit 3 of 0x0F
        push(8'h0F);
        wait_rdreq(got);
        if (got) check_frame(8'h0F, -1, 20);
        chk("pre_rst_tx", {15'd0, tx}, {15'd0, line_model(8'h0F, 20)});
        #1 reset_n = 1'b0;
        #1;
        chk("arst_tx", {15'd0, tx}, 16'd1);
        chk("arst_busy", {15'd0, busy}, 16'd0);
        chk("arst_cnt", byte_count, 16'd0);
        r3 = 8'($urandom);
        push(r3);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("rst_hold_rdreq", {15'd0, fifo_rdreq}, 16'd0);
        end
        reset_n = 1'b1;
        cnt_exp = 0;
        wait_rdreq(got);
        if (got) check_frame(r3, -1, -1);
        @(negedge clock);
        cnt_exp++;
        chk("post_rst_cnt", byte_count, 16'(cnt_exp));
        chk("post_rst_busy", {15'd0, busy}, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
